vga_sync_gen: RTL
=================

# vga_sync_gen

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz board clock. Produces the pixel coordinates and `video_on` consumed by `pixel_generation`, plus the active-low `hsync`/`vsync` sent to the connector. The block sits directly upstream of `pixel_generation`. All scan positions, including the blanking rows used for the refresh tick, are exposed raw on `x`/`y`.

## Interface

Parameters:
- `H_DISPLAY`, 640, visible columns
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width
- `H_BACK`, 48, horizontal back porch
- `V_DISPLAY`, 480, visible lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width
- `V_BACK`, 33, vertical back porch
- `CLK_DIV`, 4, clk cycles per pixel (100 MHz / 4 = 25 MHz)

Ports:
- `clk` in 1: 100 MHz system clock
- `reset` in 1: asynchronous, active-high (btnC)
- `p_tick` out 1: one-`clk` pulse per pixel period
- `x` out 10: horizontal count, 0..H_TOTAL-1 (H_TOTAL=800)
- `y` out 10: vertical count, 0..V_TOTAL-1 (V_TOTAL=525)
- `video_on` out 1: high when x<H_DISPLAY and y<V_DISPLAY
- `hsync` out 1: active-low horizontal sync
- `vsync` out 1: active-low vertical sync
- `frame_tick` out 1: one-`clk` pulse coincident with the p_tick that wraps (x,y) to (0,0)

## Operation

- Divider: `div_cnt` counts 0..CLK_DIV-1 on every `clk` and wraps.
  - `p_tick` = (div_cnt == CLK_DIV-1), combinational from the register.
  - High exactly 1 of every CLK_DIV cycles.
- Horizontal counter `h_cnt` advances only on `p_tick`:
  - if h_cnt == H_TOTAL-1, it goes to 0;
  - otherwise it increments.
- Vertical counter `v_cnt` advances only on `p_tick` with h_cnt == H_TOTAL-1:
  - if v_cnt == V_TOTAL-1, it goes to 0;
  - otherwise it increments.
- Sync windows:
  - hsync low for H_DISPLAY+H_FRONT ≤ h < H_DISPLAY+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync low for 490..491.
- `hsync`/`vsync` are registered. Each is computed from the next-state counters, so it changes on the same edge as `x`/`y`, with no skew against coordinates.
- `x` = h_cnt, `y` = v_cnt (registers, no combinational path).
- `video_on` is combinational from h_cnt/v_cnt.
- `frame_tick` = p_tick & (h_cnt == H_TOTAL-1) & (v_cnt == V_TOTAL-1).
- The downstream refresh tick (y==481, x==0) occurs once per frame, lasting CLK_DIV clk cycles. Downstream must qualify it; this block does not.

## Timing

- Reset values (asynchronous, immediate on `reset` high):
  - div_cnt=0, x=0, y=0, hsync=1, vsync=1.
  - Derived outputs during reset: p_tick=0, frame_tick=0, video_on=1.
- Reset deassertion: first p_tick occurs on the CLK_DIV-th rising edge after release, i.e. div_cnt=3. x becomes 1 on the following edge.
- Coordinate latency: x/y/hsync/vsync all update on the clk edge ending the p_tick cycle, and each value holds for CLK_DIV clks.
- Line period: 800×4 = 3200 clk. Frame period: 525×3200 = 1,680,000 clk (59.52 Hz).
- Wrap-around: (799,524) → (0,0) in one edge. No intermediate (0,525) or (800,y) value is ever visible.
- Simultaneous h-wrap and v-wrap: both counters update on the same edge.
- Reset mid-frame: all state returns to reset values on the assertion edge. No partial line is completed.
- No other inputs, so there are no handshakes. Outputs are valid every cycle.

## Structure

- Shared package `vga_pkg`:
  - H/V display, porch and sync constants;
  - derived H_TOTAL/V_TOTAL and sync start/end;
  - COORD_W=10.
- `pixel_generation` imports `vga_pkg` for X_MAX/Y_MAX instead of literals.
- One sub-module: `pixel_tick_gen` (the CLK_DIV divider producing `p_tick`). The counters and sync logic stay in `vga_sync_gen`.

## Test plan

- Reset release, run 8 clk → p_tick high on clk 4 and clk 8 only; x goes 0→1→2, each value held 4 clk; hsync=vsync=1; video_on=1.
- Run one line → hsync falls when x becomes 656 and rises when x becomes 752; video_on falls at x=640; x wraps 799→0 and y increments 0→1 on the same edge.
- Run to line 489→492 → vsync low exactly while y∈{490,491} (2×3200 clk); video_on=0 for all y≥480.
- Full frame → frame_tick pulses exactly once per 1,680,000 clk, on the clk where (x,y)=(799,524) and p_tick=1; the next edge gives (0,0).
- Assert reset at (x,y)=(300,200) with div_cnt=2 → outputs go to reset values with no clk edge needed. After release, timing matches scenario 1.
- Sample (x,y) at every p_tick over a frame → 420,000 unique positions counted and 307,200 with video_on=1. y==481&&x==0 holds for exactly 4 clk.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and coordinate helpers for the sync
// generator and its downstream pixel_generation consumer.
package vga_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned CLK_DIV   = 4;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int unsigned X_MAX = H_DISPLAY - 1;
  localparam int unsigned Y_MAX = V_DISPLAY - 1;

  typedef logic [COORD_W-1:0] coord_t;

  // True when lo <= pos < hi.
  function automatic logic in_window(input coord_t pos, input int unsigned lo,
                                     input int unsigned hi);
    return (pos >= coord_t'(lo)) && (pos < coord_t'(hi));
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Clock divider: one-clk p_tick pulse every CLK_DIV system clocks.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = vga_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       div_cnt <= '0;
    else if (p_tick) div_cnt <= '0;
    else             div_cnt <= div_cnt + DIV_W'(1);
  end

  assign p_tick = (div_cnt == DIV_W'(CLK_DIV - 1));

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan counters and sync generation; syncs are registered from the
// next-state counters so they move on the same edge as x/y.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_pkg::H_BACK,
  parameter int unsigned V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_pkg::V_BACK,
  parameter int unsigned CLK_DIV   = vga_pkg::CLK_DIV
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_tick
);

  localparam int unsigned HT      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VT      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_LO   = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_HI   = HS_LO + H_SYNC;
  localparam int unsigned VS_LO   = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_HI   = VS_LO + V_SYNC;

  coord_t h_cnt, v_cnt;
  coord_t h_next, v_next;
  logic   h_last, v_last;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  assign h_last = (h_cnt == COORD_W'(HT - 1));
  assign v_last = (v_cnt == COORD_W'(VT - 1));

  // Next scan position; both counters wrap together on the last pixel.
  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (p_tick) begin
      if (h_last) begin
        h_next = '0;
        v_next = v_last ? '0 : v_cnt + COORD_W'(1);
      end else begin
        h_next = h_cnt + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      h_cnt <= h_next;
      v_cnt <= v_next;
      hsync <= ~in_window(h_next, HS_LO, HS_HI);
      vsync <= ~in_window(v_next, VS_LO, VS_HI);
    end
  end

  assign x          = h_cnt;
  assign y          = v_cnt;
  assign video_on   = (h_cnt < COORD_W'(H_DISPLAY)) && (v_cnt < COORD_W'(V_DISPLAY));
  assign frame_tick = p_tick && h_last && v_last;

endmodule
